// File: rtl/hex_display_pkg.sv
// Shared types and constants for the hex display arbiter.
// Segment encoding is active-low, bit0=a .. bit6=g.
package hex_display_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int NUM_DIGITS = 6;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_nibble_to_seg.sv
// Combinational nibble to active-low seven-segment lookup.
// No state; the arbiter registers the result.
module hex_nibble_to_seg
  import hex_display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = SEG_LUT[nib];

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing HEX5..HEX0 between requesters.
// Optional leading-zero blanking: define HEX_LZB_EN.
module hex_display_arbiter
  import hex_display_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic                       CLOCK_50,
  input  logic                       RESET,
  input  logic [NUM_REQ-1:0]         REQ,
  input  logic [24*NUM_REQ-1:0]      REQ_DATA,
  output logic [NUM_REQ-1:0]         ACK,
  output logic [$clog2(NUM_REQ)-1:0] OWNER,
  output logic                       BUSY,
  output logic [6:0]                 HEX0,
  output logic [6:0]                 HEX1,
  output logic [6:0]                 HEX2,
  output logic [6:0]                 HEX3,
  output logic [6:0]                 HEX4,
  output logic [6:0]                 HEX5
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW =
    (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD =
    CW'(DWELL_CYCLES - 1);
  localparam logic [OW-1:0] LAST_RST =
    OW'(NUM_REQ - 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [23:0]         data_q, data_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [OW-1:0]       last_q, last_d;
  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic                found;
  logic [OW-1:0]       pick;
  int                  idx;
  int                  sel;

  logic [6:0] seg_raw [NUM_DIGITS];
  logic [6:0] seg_sel [NUM_DIGITS];
  logic [6:0] hex_q   [NUM_DIGITS];

  // Round-robin pick: first set REQ bit after last_q, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (REQ[idx]) begin
        found = 1'b1;
        pick  = OW'(idx);
      end
    end
  end

  // Next-state and grant logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    owner_d = owner_q;
    last_d  = last_q;
    ack_d   = '0;
    sel     = 24 * int'(pick);
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = DWELL;
          cnt_d   = CNT_LOAD;
          data_d  = REQ_DATA[sel +: 24];
          owner_d = pick;
          last_d  = pick;
          ack_d   = NUM_REQ'(1) << pick;
        end
      end
      DWELL: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, counter and capture registers.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      owner_q <= '0;
      last_q  <= LAST_RST;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    hex_nibble_to_seg u_dec (
      .nib (data_q[4*g +: 4]),
      .seg (seg_raw[g])
    );
  end

`ifdef HEX_LZB_EN
  logic lead;

  // Blank zero digits above the first nonzero one; HEX0 always shown.
  always_comb begin
    seg_sel = seg_raw;
    lead    = 1'b1;
    for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
      lead = lead & (data_q[4*d +: 4] == 4'h0);
      if (lead) begin
        seg_sel[d] = SEG_BLANK;
      end
    end
  end
`else
  assign seg_sel = seg_raw;
`endif

  // Display register loads once, the cycle after capture.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      hex_q <= '{default: SEG_BLANK};
    end else if (|ack_q) begin
      hex_q <= seg_sel;
    end
  end

  assign ACK   = ack_q;
  assign OWNER = owner_q;
  assign BUSY  = (state_q == DWELL);
  assign HEX0  = hex_q[0];
  assign HEX1  = hex_q[1];
  assign HEX2  = hex_q[2];
  assign HEX3  = hex_q[3];
  assign HEX4  = hex_q[4];
  assign HEX5  = hex_q[5];

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Scoreboard bench for hex_display_arbiter.
// Reference model grants from the arbitration rules; monitor checks.
module tb_hex_display_arbiter;

  localparam int N = 3;
  localparam int D = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req = '0;
  logic [24*N-1:0]   rdata = '0;
  logic [N-1:0]      ack;
  logic [1:0]        owner;
  logic              busy;
  logic [6:0]        h0, h1, h2, h3, h4, h5;

  always #5 clk = ~clk;

  hex_display_arbiter #(
    .NUM_REQ      (N),
    .DWELL_CYCLES (D)
  ) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .REQ      (req),
    .REQ_DATA (rdata),
    .ACK      (ack),
    .OWNER    (owner),
    .BUSY     (busy),
    .HEX0     (h0),
    .HEX1     (h1),
    .HEX2     (h2),
    .HEX3     (h3),
    .HEX4     (h4),
    .HEX5     (h5)
  );

  typedef struct {
    int          idx;
    logic [23:0] data;
  } grant_t;

  localparam logic [6:0] DEC [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  int     total = 0;
  int     bad = 0;
  grant_t exp_q [$];
  int     busy_left = 0;
  int     last_own = N - 1;
  bit     checking = 0;
  bit     rst_evt = 0;

  function automatic logic [41:0] disp(logic [23:0] v);
    logic [41:0] r;
    logic [3:0]  n;
    bit          z;
    z = 1;
    r = '0;
    for (int d = 5; d >= 0; d--) begin
      n = v[4*d +: 4];
`ifdef HEX_LZB_EN
      z = z && (n == 4'h0) && (d != 0);
`else
      z = 0;
`endif
      r[7*d +: 7] = z ? 7'h7F : DEC[n];
    end
    return r;
  endfunction

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: whenever the display is free and someone
  // requests, the rotating-priority winner is granted for D cycles.
  always @(posedge clk) begin
    int i;
    if (rst) begin
      busy_left = 0;
      last_own  = N - 1;
      exp_q.delete();
      rst_evt   = 1;
    end else if (busy_left == 0) begin
      for (int k = 1; k <= N; k++) begin
        i = (last_own + k) % N;
        if (req[i]) begin
          exp_q.push_back('{i, rdata[24*i +: 24]});
          last_own  = i;
          busy_left = D;
          break;
        end
      end
    end else begin
      busy_left--;
    end
  end

  logic [41:0] cur_hex = {6{7'h7F}};
  bit          pend = 0;
  logic [23:0] pend_data = '0;
  grant_t      g;

  // Monitor: compares DUT against scoreboard between edges.
  always @(negedge clk) begin
    if (checking) begin
      if (rst_evt) begin
        rst_evt = 0;
        pend    = 0;
        cur_hex = {6{7'h7F}};
      end else if (pend) begin
        pend    = 0;
        cur_hex = disp(pend_data);
      end
      chk("hex", {h5, h4, h3, h2, h1, h0}, cur_hex);
      chk("busy", busy, busy_left > 0);
      if (exp_q.size() > 0) begin
        g = exp_q.pop_front();
        chk("ack", ack, N'(1) << g.idx);
        chk("owner", owner, g.idx);
        pend      = 1;
        pend_data = g.data;
      end else begin
        chk("ack_idle", ack, 0);
      end
    end
  end

  task automatic hold_until_ack(int i);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ack[i]) begin
        req[i] = 1'b0;
        return;
      end
    end
    total++;
    bad++;
    req[i] = 1'b0;
    $display("FAIL ack_wait req=%0d got=none want=ack", i);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hex", {h5, h4, h3, h2, h1, h0}, {6{7'h7F}});
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    checking = 1;
    rst = 1'b0;

    rdata[23:0] = 24'h123456;
    req = 3'b001;
    hold_until_ack(0);
    repeat (8) @(negedge clk);

    pulse_reset();
    rdata[47:24] = 24'h00000A;
    rdata[23:0]  = 24'h0BEEF0;
    req = 3'b011;
    repeat (18) @(negedge clk);
    req = '0;
    repeat (6) @(negedge clk);

    req = 3'b001;
    hold_until_ack(0);
    repeat (2) @(negedge clk);
    req[1] = 1'b1;
    hold_until_ack(1);
    repeat (6) @(negedge clk);

    req = 3'b001;
    hold_until_ack(0);
    @(negedge clk);
    pulse_reset();
    req = 3'b110;
    hold_until_ack(1);
    req = '0;
    repeat (6) @(negedge clk);
    req = 3'b111;
    hold_until_ack(0);
    req = '0;
    repeat (6) @(negedge clk);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(399) == 0);
      for (int i = 0; i < N; i++) begin
        if (req[i] && ack[i]) begin
          if ($urandom_range(3) == 0) begin
            rdata[24*i +: 24] =
              24'($urandom) >> (4 * $urandom_range(6));
          end else begin
            req[i] = 1'b0;
          end
        end else if (!req[i]) begin
          if ($urandom_range(2) == 0) begin
            req[i] = 1'b1;
            rdata[24*i +: 24] =
              24'($urandom) >> (4 * $urandom_range(6));
          end
        end else if ($urandom_range(30) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    rst = 1'b0;
    req = '0;
    repeat (12) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
